// File: rtl/seq_arith_4x1b_operand_ser.sv
// seq_arith_4x1b_operand_ser
//
// Parallel-to-serial operand front end for the bit-serial adder. It accepts a
// pair of NBITS-wide operands over a val/rdy handshake and buffers one word.
// It emits both operands LSB-first, one bit per cycle, in fixed NBITS-cycle
// frames. Frames never stall, and a frame with no accepted word sends zeros.
//
// Ports
//   clk        in   1      clock; all state changes on posedge
//   reset_n    in   1      asynchronous reset, active-low
//   in_val     in   1      operand pair valid
//   in_rdy     out  1      block can accept an operand pair (= no word pending)
//   in_a       in   NBITS  operand A, serialised onto ser0
//   in_b       in   NBITS  operand B, serialised onto ser1
//   ser0       out  1      current bit of A, LSB first
//   ser1       out  1      current bit of B, LSB first
//   ser_first  out  1      high on bit 0 of every frame
//   busy       out  1      current frame carries an accepted word (0 = filler)
module seq_arith_4x1b_operand_ser #(
    parameter int NBITS = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic [NBITS-1:0] in_a,
    input  logic [NBITS-1:0] in_b,
    output logic             ser0,
    output logic             ser1,
    output logic             ser_first,
    output logic             busy
);

    localparam int               CNT_W    = (NBITS > 2) ? $clog2(NBITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBITS - 1);

    logic [CNT_W-1:0] cnt;
    logic [NBITS-1:0] sh_a;
    logic [NBITS-1:0] sh_b;
    logic [NBITS-1:0] pend_a;
    logic [NBITS-1:0] pend_b;
    logic             pend_val;
    logic             fire;
    logic             frame_end;

    assign in_rdy    = !pend_val;
    assign fire      = in_val && in_rdy;
    assign frame_end = (cnt == CNT_LAST);

    assign ser0      = sh_a[0];
    assign ser1      = sh_b[0];
    assign ser_first = (cnt == '0);

    // Frame counter, shift registers and pending flag.
    // At the frame boundary a pending word has priority. Otherwise a word
    // offered in that same cycle goes straight into the shifters, so the
    // one-word buffer is not occupied.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            sh_a     <= '0;
            sh_b     <= '0;
            pend_val <= 1'b0;
            busy     <= 1'b0;
        end else begin
            cnt <= frame_end ? '0 : cnt + CNT_W'(1);
            if (frame_end) begin
                if (pend_val) begin
                    sh_a     <= pend_a;
                    sh_b     <= pend_b;
                    pend_val <= 1'b0;
                    busy     <= 1'b1;
                end else if (fire) begin
                    sh_a <= in_a;
                    sh_b <= in_b;
                    busy <= 1'b1;
                end else begin
                    sh_a <= '0;
                    sh_b <= '0;
                    busy <= 1'b0;
                end
            end else begin
                sh_a <= {1'b0, sh_a[NBITS-1:1]};
                sh_b <= {1'b0, sh_b[NBITS-1:1]};
                if (fire) begin
                    pend_val <= 1'b1;
                end
            end
        end
    end

    // Pending word data; only meaningful while pend_val is set, so it needs
    // no reset.
    always_ff @(posedge clk) begin
        if (fire && !frame_end) begin
            pend_a <= in_a;
            pend_b <= in_b;
        end
    end

endmodule
